// File: rtl/apm_pkg.sv
// Shared constants, P-state lookup tables and helpers for the NPU power manager.
package apm_pkg;

   localparam logic [2:0]  P_MAX           = 3'd7;
   localparam logic [2:0]  P_MIN           = 3'd0;
   localparam logic [7:0]  THERMAL_LIMIT_C = 8'd95;
   localparam logic [15:0] GRADE3_MIN      = 16'd8000;
   localparam logic [15:0] GRADE2_MIN      = 16'd4000;
   localparam logic [15:0] GRADE1_MIN      = 16'd1000;

   typedef enum logic [1:0] {
      PREC_INT8 = 2'b00,
      PREC_INT4 = 2'b01,
      PREC_FP16 = 2'b10,
      PREC_FP32 = 2'b11
   } precision_e;

   typedef enum logic [1:0] {
      DVFS_HOLD = 2'd0,
      DVFS_UP   = 2'd1,
      DVFS_DOWN = 2'd2,
      DVFS_PIN  = 2'd3
   } dvfs_action_e;

   function automatic logic [15:0] freq_mhz(input logic [2:0] code);
      return 16'd100 * ({13'd0, code} + 16'd1);
   endfunction

   function automatic logic [15:0] volt_mv(input logic [2:0] code);
      return 16'd600 + 16'd50 * {13'd0, code};
   endfunction

   function automatic logic [15:0] leak_coeff_mw(input logic [2:0] code);
      return 16'd40 + 16'd50 * {13'd0, code};
   endfunction

   function automatic logic [15:0] sat16(input logic [63:0] value);
      return (value > 64'd65535) ? 16'hFFFF : value[15:0];
   endfunction

endpackage

// File: rtl/apm_power_model.sv
// Telemetry model: turns the applied codes plus activity, ops and temperature into
// registered frequency/voltage readbacks, dynamic/leakage/total power, throughput and efficiency.
module apm_power_model
   import apm_pkg::*;
#(
   parameter int unsigned CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       freq_code,
   input  logic [2:0]       volt_code,
   input  logic [CNT_W-1:0] active_cnt,
   input  logic [15:0]      ops_count,
   input  logic [1:0]       precision_mode,
   input  logic [7:0]       temperature,
   input  logic [7:0]       leak_ref_temp_c,
   input  logic [15:0]      leak_alpha_milli,
   output logic [15:0]      freq_mhz_out,
   output logic [15:0]      volt_mv_out,
   output logic [15:0]      dyn_mw,
   output logic [15:0]      leak_mw,
   output logic [15:0]      power_mw,
   output logic [15:0]      tops,
   output logic [15:0]      eff,
   output logic [1:0]       grade
);

   logic [15:0] freq_q, freq_d, volt_q, volt_d, dyn_q, dyn_d, leak_q, leak_d;
   logic [15:0] power_q, power_d, tops_q, tops_d, eff_q, eff_d;
   logic [1:0]  grade_q, grade_d;
   logic [15:0] coeff_s, power_div_s;
   logic [63:0] vsq_s, dyn_base_s, dyn_scaled_s, tops_raw_s;
   logic signed [63:0] leak_num_s, leak_raw_s;

   // Power/performance arithmetic from the currently applied codes
   always_comb begin
      freq_d  = freq_mhz(freq_code);
      volt_d  = volt_mv(volt_code);
      coeff_s = leak_coeff_mw(volt_code);
      vsq_s      = (64'(volt_d) * 64'(volt_d)) / 64'd1000;
      dyn_base_s = (64'(active_cnt) * 64'(freq_d) * vsq_s) / 64'd40000;
      tops_raw_s = (64'(ops_count) * 64'(freq_d)) / 64'd1000;
      case (precision_mode)
         PREC_INT4: begin
            dyn_scaled_s = dyn_base_s >> 1;
            tops_raw_s   = tops_raw_s << 1;
         end
         PREC_FP16: dyn_scaled_s = dyn_base_s << 1;
         PREC_FP32: dyn_scaled_s = dyn_base_s << 2;
         default:   dyn_scaled_s = dyn_base_s;
      endcase
      dyn_d  = sat16(dyn_scaled_s);
      tops_d = sat16(tops_raw_s);

      // Wide signed math so large alpha/temperature spans cannot wrap before clamping
      leak_num_s = $signed(64'(coeff_s)) * (64'sd1000 + $signed(64'(leak_alpha_milli)) *
                   ($signed(64'(temperature)) - $signed(64'(leak_ref_temp_c))));
      leak_raw_s = leak_num_s / 64'sd1000;
      if (leak_raw_s < 64'sd1) begin
         leak_d = 16'd1;
      end else if (leak_raw_s > 64'sd65535) begin
         leak_d = 16'hFFFF;
      end else begin
         leak_d = 16'(leak_raw_s);
      end

      power_d     = sat16(64'(dyn_d) + 64'(leak_d));
      power_div_s = (power_d == 16'd0) ? 16'd1 : power_d;
      eff_d       = sat16((64'(tops_d) * 64'd1000) / 64'(power_div_s));
      if (eff_d >= GRADE3_MIN) begin
         grade_d = 2'd3;
      end else if (eff_d >= GRADE2_MIN) begin
         grade_d = 2'd2;
      end else if (eff_d >= GRADE1_MIN) begin
         grade_d = 2'd1;
      end else begin
         grade_d = 2'd0;
      end
   end

   // Telemetry registers
   always_ff @(posedge clk) begin
      if (reset) begin
         freq_q <= 16'd0; volt_q <= 16'd0; dyn_q <= 16'd0; leak_q <= 16'd0;
         power_q <= 16'd0; tops_q <= 16'd0; eff_q <= 16'd0; grade_q <= 2'd0;
      end else begin
         freq_q <= freq_d; volt_q <= volt_d; dyn_q <= dyn_d; leak_q <= leak_d;
         power_q <= power_d; tops_q <= tops_d; eff_q <= eff_d; grade_q <= grade_d;
      end
   end

   assign freq_mhz_out = freq_q;
   assign volt_mv_out  = volt_q;
   assign dyn_mw       = dyn_q;
   assign leak_mw      = leak_q;
   assign power_mw     = power_q;
   assign tops         = tops_q;
   assign eff          = eff_q;
   assign grade        = grade_q;

endmodule

// File: rtl/advanced_power_manager.sv
// NPU power/DVFS controller: per-PE and per-domain gating, utilization tracking and
// P-state selection, with the power/performance telemetry delegated to apm_power_model.
module advanced_power_manager
   import apm_pkg::*;
#(
   parameter int unsigned NUM_PES     = 64,
   parameter int unsigned NUM_DOMAINS = NUM_PES / 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             power_mode,
   input  logic [15:0]            utilization_target,
   input  logic [15:0]            performance_target,
   input  logic [NUM_PES-1:0]     pe_active,
   input  logic [NUM_PES-1:0]     pe_request,
   input  logic [15:0]            current_ops_count,
   input  logic [1:0]             precision_mode,
   input  logic [7:0]             temperature,
   input  logic [15:0]            power_budget,
   input  logic [7:0]             util_high_thresh_pct_cfg,
   input  logic [7:0]             util_low_thresh_pct_cfg,
   input  logic [15:0]            perf_hyst_margin_milli_cfg,
   input  logic [7:0]             dvfs_min_settle_cycles_cfg,
   input  logic                   frequency_override_en,
   input  logic                   voltage_override_en,
   input  logic [2:0]             frequency_override,
   input  logic [2:0]             voltage_override,
   input  logic [7:0]             leak_ref_temp_c,
   input  logic [15:0]            leak_alpha_milli,
   output logic [NUM_DOMAINS-1:0] domain_power_enable,
   output logic [NUM_DOMAINS-1:0] domain_clock_enable,
   output logic [NUM_PES-1:0]     pe_power_gate,
   output logic [NUM_PES-1:0]     pe_clock_gate,
   output logic [2:0]             voltage_setting,
   output logic [2:0]             frequency_setting,
   output logic [15:0]            current_power_mw,
   output logic [15:0]            current_tops,
   output logic [15:0]            efficiency_tops_w,
   output logic [1:0]             power_efficiency_grade,
   output logic [15:0]            dynamic_power_mw,
   output logic [15:0]            leakage_power_mw,
   output logic [15:0]            utilization_ma_out,
   output logic [15:0]            current_freq_mhz,
   output logic [15:0]            current_voltage_mv
);

   localparam int unsigned CNT_W = $clog2(NUM_PES + 1);

   logic [NUM_PES-1:0]     idle_s, pg_q, pg_d, cg_q, cg_d;
   logic [4:0]             idle_cnt_q [NUM_PES];
   logic [4:0]             idle_cnt_d [NUM_PES];
   logic [NUM_DOMAINS-1:0] dpe_q, dpe_d, dce_q, dce_d;
   logic [CNT_W-1:0]       active_cnt_s;
   logic [15:0]            util_x10_s, util_ma_q, util_ma_d;
   logic signed [17:0]     util_diff_s;
   logic [2:0]             pstate_q, pstate_d, freq_code_q, freq_code_d, volt_code_q, volt_code_d;
   logic [7:0]             settle_cnt_q, settle_cnt_d;
   logic                   thermal_s, over_budget_s, perf_high_s, perf_low_s, util_high_s, util_low_s;
   dvfs_action_e           action_s;
   logic                   util_target_unused;

   assign util_target_unused = ^utilization_target;
   assign active_cnt_s = CNT_W'($countones(pe_active));
   assign idle_s       = ~(pe_active | pe_request);

   // PE/domain gating and utilization moving average
   always_comb begin
      cg_d = idle_s;
      for (int i = 0; i < NUM_PES; i++) begin
         idle_cnt_d[i] = idle_s[i] ? ((idle_cnt_q[i] == 5'd16) ? 5'd16 : idle_cnt_q[i] + 5'd1) : 5'd0;
         pg_d[i]       = idle_s[i] && (idle_cnt_q[i] >= 5'd15);
      end
      for (int d = 0; d < NUM_DOMAINS; d++) begin
         dce_d[d] = |(~cg_d[d*8 +: 8]);
         dpe_d[d] = |(~pg_d[d*8 +: 8]);
      end
      util_x10_s  = 16'((32'(active_cnt_s) * 32'd100) / 32'(NUM_PES)) * 16'd10;
      util_diff_s = $signed({2'b00, util_x10_s}) - $signed({2'b00, util_ma_q});
      util_ma_d   = util_ma_q + 16'(util_diff_s >>> 3);
   end

   // DVFS decision: thermal and pinned modes first, then settled +-1 auto steps
   always_comb begin
      thermal_s     = temperature >= THERMAL_LIMIT_C;
      over_budget_s = current_power_mw > power_budget;
      perf_high_s   = {1'b0, current_tops} > ({1'b0, performance_target} + {1'b0, perf_hyst_margin_milli_cfg});
      perf_low_s    = ({1'b0, current_tops} + {1'b0, perf_hyst_margin_milli_cfg}) < {1'b0, performance_target};
      util_high_s   = util_ma_q > ({8'd0, util_high_thresh_pct_cfg} * 16'd10);
      util_low_s    = util_ma_q < ({8'd0, util_low_thresh_pct_cfg} * 16'd10);
      action_s      = DVFS_HOLD;
      pstate_d      = pstate_q;
      settle_cnt_d  = (settle_cnt_q == 8'hFF) ? 8'hFF : settle_cnt_q + 8'd1;
      if (thermal_s) begin
         action_s = DVFS_PIN;
         pstate_d = P_MIN;
      end else if (power_mode == 8'd1) begin
         action_s = DVFS_PIN;
         pstate_d = P_MAX;
      end else if (power_mode == 8'd2) begin
         action_s = DVFS_PIN;
         pstate_d = P_MIN;
      end else if (settle_cnt_q >= dvfs_min_settle_cycles_cfg) begin
         if (over_budget_s) begin
            action_s = (pstate_q != P_MIN) ? DVFS_DOWN : DVFS_HOLD;
         end else if (util_low_s && perf_high_s) begin
            action_s = (pstate_q != P_MIN) ? DVFS_DOWN : DVFS_HOLD;
         end else if (util_high_s || perf_low_s) begin
            action_s = (pstate_q != P_MAX) ? DVFS_UP : DVFS_HOLD;
         end else begin
            action_s = DVFS_HOLD;
         end
      end else begin
         action_s = DVFS_HOLD;
      end
      case (action_s)
         DVFS_UP: begin
            pstate_d     = pstate_q + 3'd1;
            settle_cnt_d = 8'd0;
         end
         DVFS_DOWN: begin
            pstate_d     = pstate_q - 3'd1;
            settle_cnt_d = 8'd0;
         end
         DVFS_PIN: settle_cnt_d = (pstate_d != pstate_q) ? 8'd0 : settle_cnt_d;
         default:  pstate_d = pstate_q;
      endcase
      freq_code_d = frequency_override_en ? frequency_override : pstate_d;
      volt_code_d = voltage_override_en   ? voltage_override   : pstate_d;
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pg_q <= '0; cg_q <= '0; dpe_q <= '1; dce_q <= '1;
         for (int i = 0; i < NUM_PES; i++) idle_cnt_q[i] <= 5'd0;
         util_ma_q <= 16'd0; pstate_q <= 3'd0; settle_cnt_q <= 8'd0;
         freq_code_q <= 3'd0; volt_code_q <= 3'd0;
      end else begin
         pg_q <= pg_d; cg_q <= cg_d; dpe_q <= dpe_d; dce_q <= dce_d;
         for (int i = 0; i < NUM_PES; i++) idle_cnt_q[i] <= idle_cnt_d[i];
         util_ma_q <= util_ma_d; pstate_q <= pstate_d; settle_cnt_q <= settle_cnt_d;
         freq_code_q <= freq_code_d; volt_code_q <= volt_code_d;
      end
   end

   assign pe_power_gate       = pg_q;
   assign pe_clock_gate       = cg_q;
   assign domain_power_enable = dpe_q;
   assign domain_clock_enable = dce_q;
   assign utilization_ma_out  = util_ma_q;
   assign frequency_setting   = freq_code_q;
   assign voltage_setting     = volt_code_q;

   apm_power_model #(.CNT_W(CNT_W)) u_power_model (
      .clk              (clk),
      .reset            (reset),
      .freq_code        (freq_code_q),
      .volt_code        (volt_code_q),
      .active_cnt       (active_cnt_s),
      .ops_count        (current_ops_count),
      .precision_mode   (precision_mode),
      .temperature      (temperature),
      .leak_ref_temp_c  (leak_ref_temp_c),
      .leak_alpha_milli (leak_alpha_milli),
      .freq_mhz_out     (current_freq_mhz),
      .volt_mv_out      (current_voltage_mv),
      .dyn_mw           (dynamic_power_mw),
      .leak_mw          (leakage_power_mw),
      .power_mw         (current_power_mw),
      .tops             (current_tops),
      .eff              (efficiency_tops_w),
      .grade            (power_efficiency_grade)
   );

endmodule

// File: tb/tb_advanced_power_manager.sv
// Directed self-checking bench for advanced_power_manager with hand-computed expectations.
module tb_advanced_power_manager;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  power_mode;
   logic [15:0] utilization_target, performance_target, current_ops_count, power_budget;
   logic [63:0] pe_active, pe_request;
   logic [1:0]  precision_mode;
   logic [7:0]  temperature, util_high_thresh_pct_cfg, util_low_thresh_pct_cfg, dvfs_min_settle_cycles_cfg;
   logic [15:0] perf_hyst_margin_milli_cfg, leak_alpha_milli;
   logic        frequency_override_en, voltage_override_en;
   logic [2:0]  frequency_override, voltage_override;
   logic [7:0]  leak_ref_temp_c;
   logic [7:0]  domain_power_enable, domain_clock_enable;
   logic [63:0] pe_power_gate, pe_clock_gate;
   logic [2:0]  voltage_setting, frequency_setting;
   logic [15:0] current_power_mw, current_tops, efficiency_tops_w, dynamic_power_mw, leakage_power_mw;
   logic [15:0] utilization_ma_out, current_freq_mhz, current_voltage_mv;
   logic [1:0]  power_efficiency_grade;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_code;
   int gap;

   always #5 clk = ~clk;

   advanced_power_manager #(.NUM_PES(64)) dut (
      .clk(clk), .reset(reset), .power_mode(power_mode),
      .utilization_target(utilization_target), .performance_target(performance_target),
      .pe_active(pe_active), .pe_request(pe_request), .current_ops_count(current_ops_count),
      .precision_mode(precision_mode), .temperature(temperature), .power_budget(power_budget),
      .util_high_thresh_pct_cfg(util_high_thresh_pct_cfg), .util_low_thresh_pct_cfg(util_low_thresh_pct_cfg),
      .perf_hyst_margin_milli_cfg(perf_hyst_margin_milli_cfg),
      .dvfs_min_settle_cycles_cfg(dvfs_min_settle_cycles_cfg),
      .frequency_override_en(frequency_override_en), .voltage_override_en(voltage_override_en),
      .frequency_override(frequency_override), .voltage_override(voltage_override),
      .leak_ref_temp_c(leak_ref_temp_c), .leak_alpha_milli(leak_alpha_milli),
      .domain_power_enable(domain_power_enable), .domain_clock_enable(domain_clock_enable),
      .pe_power_gate(pe_power_gate), .pe_clock_gate(pe_clock_gate),
      .voltage_setting(voltage_setting), .frequency_setting(frequency_setting),
      .current_power_mw(current_power_mw), .current_tops(current_tops),
      .efficiency_tops_w(efficiency_tops_w), .power_efficiency_grade(power_efficiency_grade),
      .dynamic_power_mw(dynamic_power_mw), .leakage_power_mw(leakage_power_mw),
      .utilization_ma_out(utilization_ma_out), .current_freq_mhz(current_freq_mhz),
      .current_voltage_mv(current_voltage_mv)
   );

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; power_mode = 8'd0; utilization_target = 16'd0; performance_target = 16'd0;
      pe_active = '1; pe_request = '0; current_ops_count = 16'd1000; precision_mode = 2'b00;
      temperature = 8'd50; power_budget = 16'hFFFF; util_high_thresh_pct_cfg = 8'd100;
      util_low_thresh_pct_cfg = 8'd0; perf_hyst_margin_milli_cfg = 16'd0;
      dvfs_min_settle_cycles_cfg = 8'd255; frequency_override_en = 1'b1; voltage_override_en = 1'b1;
      frequency_override = 3'd3; voltage_override = 3'd3; leak_ref_temp_c = 8'd50; leak_alpha_milli = 16'd20;
      tick(2);
      check("rst_freq_code", frequency_setting, 0);
      check("rst_volt_code", voltage_setting, 0);
      check("rst_dom_pwr", domain_power_enable, 8'hFF);
      check("rst_dom_clk", domain_clock_enable, 8'hFF);
      check("rst_pe_pg", pe_power_gate, 0);
      check("rst_pe_cg", pe_clock_gate, 0);
      check("rst_power", current_power_mw, 0);
      check("rst_util", utilization_ma_out, 0);
      check("rst_freq_mhz", current_freq_mhz, 0);

      // Override f=v=3, all PEs active, INT8, 1000 ops
      reset = 1'b0;
      tick(1);
      check("ovr_freq_code", frequency_setting, 3);
      check("ovr_volt_code", voltage_setting, 3);
      check("util_ma_1", utilization_ma_out, 125);
      tick(1);
      check("util_ma_2", utilization_ma_out, 234);
      check("freq_mhz_3", current_freq_mhz, 400);
      check("volt_mv_3", current_voltage_mv, 750);
      check("leak_ref", leakage_power_mw, 190);
      check("dyn_int8", dynamic_power_mw, 359);
      check("power_int8", current_power_mw, 549);
      check("tops_int8", current_tops, 400);
      check("eff_int8", efficiency_tops_w, 728);
      check("grade_int8", power_efficiency_grade, 0);
      precision_mode = 2'b11;
      tick(1);
      check("dyn_fp32", dynamic_power_mw, 1436);
      precision_mode = 2'b01;
      tick(1);
      check("dyn_int4", dynamic_power_mw, 179);
      check("tops_int4", current_tops, 800);
      check("eff_int4", efficiency_tops_w, 2168);
      check("grade_int4", power_efficiency_grade, 1);
      precision_mode = 2'b00;
      temperature = 8'd30;  tick(1); check("leak_t30", leakage_power_mw, 114);
      temperature = 8'd40;  tick(1); check("leak_t40", leakage_power_mw, 152);
      temperature = 8'd60;  tick(1); check("leak_t60", leakage_power_mw, 228);
      temperature = 8'd70;  tick(1); check("leak_t70", leakage_power_mw, 266);
      temperature = 8'd0;   tick(1); check("leak_t0_clamp", leakage_power_mw, 1);
      temperature = 8'd255; tick(1); check("leak_t255", leakage_power_mw, 969);
      check("ovr_hold_hot", frequency_setting, 3);
      temperature = 8'd50;

      // Mid-operation reset, then idle gating
      reset = 1'b1;
      tick(1);
      check("midrst_freq", frequency_setting, 0);
      check("midrst_dom", domain_power_enable, 8'hFF);
      pe_active = '0; pe_request = '0; frequency_override_en = 1'b0; voltage_override_en = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(1);
      check("cg_all", pe_clock_gate, 64'hFFFF_FFFF_FFFF_FFFF);
      check("dom_clk_off", domain_clock_enable, 8'h00);
      tick(14);
      check("pg_not_yet", pe_power_gate, 0);
      check("dom_pwr_still", domain_power_enable, 8'hFF);
      tick(1);
      check("pg_all", pe_power_gate, 64'hFFFF_FFFF_FFFF_FFFF);
      check("dom_pwr_off", domain_power_enable, 8'h00);
      pe_request = 64'h20;
      tick(1);
      check("pg_wake", pe_power_gate, 64'hFFFF_FFFF_FFFF_FFDF);
      check("cg_wake", pe_clock_gate, 64'hFFFF_FFFF_FFFF_FFDF);
      check("dom_pwr_wake", domain_power_enable, 8'h01);
      check("dom_clk_wake", domain_clock_enable, 8'h01);

      // Auto DVFS climbing with settle spacing
      reset = 1'b1; pe_active = '1; pe_request = '0; current_ops_count = 16'd0;
      power_budget = 16'd5000; performance_target = 16'hFFFF; dvfs_min_settle_cycles_cfg = 8'd10;
      tick(2);
      reset = 1'b0;
      exp_code = 0; gap = 0;
      for (int cyc = 0; cyc < 150 && exp_code < 7; cyc++) begin
         tick(1);
         gap++;
         if (frequency_setting !== 3'(exp_code)) begin
            exp_code++;
            check("up_step", frequency_setting, 64'(exp_code));
            check("up_volt", voltage_setting, 64'(exp_code));
            check("up_gap_ge10", 64'(gap >= 10), 1);
            gap = 0;
         end
      end
      check("up_reached7", frequency_setting, 7);
      tick(30);
      check("up_sat7", frequency_setting, 7);
      check("freq_mhz_7", current_freq_mhz, 800);
      check("volt_mv_7", current_voltage_mv, 950);

      // Over budget walks back down to 0 and holds
      power_budget = 16'd10;
      for (int cyc = 0; cyc < 150 && exp_code > 0; cyc++) begin
         tick(1);
         if (frequency_setting !== 3'(exp_code)) begin
            exp_code--;
            check("down_step", frequency_setting, 64'(exp_code));
         end
      end
      check("down_reached0", frequency_setting, 0);
      tick(30);
      check("down_hold0", frequency_setting, 0);

      // Thermal limit forces code 0 from a raised state
      power_budget = 16'd5000;
      for (int cyc = 0; cyc < 100 && frequency_setting !== 3'd3; cyc++) tick(1);
      check("therm_pre3", frequency_setting, 3);
      temperature = 8'd96;
      tick(1);
      check("therm_force0", frequency_setting, 0);
      tick(20);
      check("therm_hold0", voltage_setting, 0);
      temperature = 8'd50;

      // Pinned modes
      power_mode = 8'd1;
      tick(1);
      check("pin_p7", frequency_setting, 7);
      power_mode = 8'd2;
      tick(1);
      check("pin_p0", frequency_setting, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
